// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between IF and DM ports.
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of fixed DM priority.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_ack,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            stall_if,
    output logic            stall_mem
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    typedef struct packed {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    state_t        r_state, w_state_nxt;
    cmd_t          r_cmd, w_cmd_i, w_cmd_d;
    logic          r_mem_req;
    logic          r_if_ack, r_dm_ack, r_bus_err;
    logic [DW-1:0] r_if_rdata, r_dm_rdata;
    logic [CW-1:0] r_cnt;
    logic          w_busy, w_timeout, w_done, w_pick_d;

    // The transaction aborts in the cycle whose missing ack would make the wait count MAX_WAIT.
    assign w_busy    = (r_state != IDLE);
    assign w_timeout = w_busy & ~mem_ack & (r_cnt == CNT_LAST);
    assign w_done    = w_busy & (mem_ack | w_timeout);

`ifdef MEM_ARB_RR_EN
    logic r_rr_d;  // 1: DM preferred on a tie

    assign w_pick_d = dm_req & (~if_req | r_rr_d);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_rr_d <= 1'b1;
        else if (w_done)
            r_rr_d <= (r_state == GNT_I);
    end
`else
    assign w_pick_d = dm_req;
`endif

    always_comb begin
        w_cmd_i       = '0;
        w_cmd_i.be    = {BW{1'b1}};
        w_cmd_i.addr  = if_addr;
        w_cmd_d       = '0;
        w_cmd_d.we    = dm_we;
        w_cmd_d.be    = dm_we ? dm_be : {BW{1'b1}};
        w_cmd_d.addr  = dm_addr;
        w_cmd_d.wdata = dm_wdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_d)
                    w_state_nxt = GNT_D;
                else if (if_req)
                    w_state_nxt = GNT_I;
            end
            GNT_I, GNT_D: begin
                if (w_done)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cmd      <= '0;
            r_mem_req  <= 1'b0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_bus_err  <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_cnt      <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_dm_ack  <= 1'b0;
            r_bus_err <= 1'b0;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_pick_d) begin
                    r_cmd     <= w_cmd_d;
                    r_mem_req <= 1'b1;
                end else if (if_req) begin
                    r_cmd     <= w_cmd_i;
                    r_mem_req <= 1'b1;
                end
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_cnt     <= '0;
                r_bus_err <= w_timeout;
                if (r_state == GNT_D) begin
                    r_dm_ack   <= 1'b1;
                    r_dm_rdata <= w_timeout ? '0 : mem_rdata;
                end else begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= w_timeout ? '0 : mem_rdata;
                end
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_cmd.we;
    assign mem_be    = r_cmd.be;
    assign mem_addr  = r_cmd.addr;
    assign mem_wdata = r_cmd.wdata;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign bus_err   = r_bus_err;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed literal checks.
// Expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;
    localparam int MW = 4;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_ack, dm_ack, bus_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall_if, stall_mem;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks 'lat' cycles after mem_req rises (lat<0 never acks).
    int          lat    = 0;
    logic [31:0] rd_val = '0;
    bit          stray  = 0;
    int          wcnt   = 0;
    always @(posedge CLK) begin
        #1;
        if (mem_req) begin
            mem_ack   = (lat >= 0) && (wcnt == lat);
            mem_rdata = mem_ack ? rd_val : ~rd_val;
            wcnt++;
        end else begin
            mem_ack   = stray;
            mem_rdata = ~rd_val;
            wcnt      = 0;
        end
    end

    // Model: one outstanding transaction, outcome decided by ack or elapsed wait cycles.
    bit          m_busy, m_is_d, m_pref_d, m_store;
    int          m_waited;
    bit          e_mem_req, e_we, e_if_ack, e_dm_ack, e_err;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata, got;
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_busy = 0; m_is_d = 0; m_pref_d = 1; m_store = 0; m_waited = 0;
            e_mem_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
            e_if_ack = 0; e_dm_ack = 0; e_err = 0; e_if_rdata = '0; e_dm_rdata = '0;
        end else begin
            e_if_ack = 0; e_dm_ack = 0; e_err = 0;
            if (m_busy) begin
                if (mem_ack || (m_waited + 1 >= MW)) begin
                    got   = mem_ack ? mem_rdata : 32'h0;
                    e_err = !mem_ack;
                    if (m_is_d) begin e_dm_ack = 1; e_dm_rdata = got; end
                    else begin e_if_ack = 1; e_if_rdata = got; end
                    m_store = m_is_d && e_we;
                    m_pref_d = !m_is_d;
                    m_busy = 0; m_waited = 0; e_mem_req = 0;
                end else begin
                    m_waited++;
                end
            end else if (if_req || dm_req) begin
`ifdef MEM_ARB_RR_EN
                m_is_d = dm_req && (!if_req || m_pref_d);
`else
                m_is_d = dm_req;
`endif
                m_busy = 1; m_waited = 0; e_mem_req = 1;
                if (m_is_d) begin
                    e_we = dm_we; e_be = dm_we ? dm_be : 4'hF; e_addr = dm_addr; e_wdata = dm_wdata;
                end else begin
                    e_we = 0; e_be = 4'hF; e_addr = if_addr; e_wdata = '0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RSTn && chk_en) begin
            chk("mem_req", 32'(mem_req), 32'(e_mem_req));
            if (e_mem_req) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_be", 32'(mem_be), 32'(e_be));
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("if_ack", 32'(if_ack), 32'(e_if_ack));
            chk("dm_ack", 32'(dm_ack), 32'(e_dm_ack));
            chk("bus_err", 32'(bus_err), 32'(e_err));
            if (e_if_ack) chk("if_rdata", if_rdata, e_if_rdata);
            if (e_dm_ack && (!m_store || e_err)) chk("dm_rdata", dm_rdata, e_dm_rdata);
            chk("stall_if", 32'(stall_if), 32'(if_req & ~e_if_ack));
            chk("stall_mem", 32'(stall_mem), 32'(dm_req & ~e_dm_ack));
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic xact(input bit d, input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int l, input logic [31:0] rv, input int drop_at,
                        output int ack_cyc, output int req_hi, output int other_ack,
                        output logic [31:0] rdata, output bit err,
                        output logic [31:0] f_addr, output logic [3:0] f_be, output bit f_we);
        bit seen = 0;
        lat = l; rd_val = rv;
        ack_cyc = -1; req_hi = 0; other_ack = 0; rdata = 'x; err = 0;
        f_addr = 'x; f_be = 'x; f_we = 0;
        if (d) begin dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wdata; dm_req = 1; end
        else begin if_addr = addr; if_req = 1; end
        for (int c = 1; c <= 20; c++) begin
            step();
            if (mem_req) begin
                req_hi++;
                if (!seen) begin seen = 1; f_addr = mem_addr; f_be = mem_be; f_we = mem_we; end
            end
            if (c == drop_at) begin if (d) dm_req = 0; else if_req = 0; end
            if (d ? if_ack : dm_ack) other_ack++;
            if (d ? dm_ack : if_ack) begin
                ack_cyc = c; rdata = d ? dm_rdata : if_rdata; err = bus_err;
                if (d) dm_req = 0; else if_req = 0;
                break;
            end
        end
    endtask

    int          ac, rh, oa, cnt;
    logic [31:0] rd, fa;
    logic [3:0]  fb, seq;
    bit          er, fw;

    initial begin
        RSTn = 0; if_req = 0; dm_req = 0; dm_we = 0; dm_be = '0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        #3;
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst mem_be", 32'(mem_be), 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst acks", 32'({if_ack, dm_ack, bus_err}), 0);
        chk("rst rdata", if_rdata | dm_rdata, 0);
        step(); step();
        RSTn = 1; chk_en = 1;
        step();

        // IF fetch, zero-wait memory
        xact(0, 0, 4'h0, 32'h100, 32'h0, 0, 32'h0000_0013, 0, ac, rh, oa, rd, er, fa, fb, fw);
        chk("if0 latency", 32'(ac), 2);
        chk("if0 rdata", rd, 32'h13);
        chk("if0 addr", fa, 32'h100);
        chk("if0 be", 32'(fb), 32'hF);
        chk("if0 req cycles", 32'(rh), 1);

        // Store, 3-wait memory
        xact(1, 1, 4'h3, 32'h2000, 32'hDEAD_BEEF, 3, 32'h1111_1111, 0, ac, rh, oa, rd, er, fa, fb, fw);
        chk("st latency", 32'(ac), 5);
        chk("st req cycles", 32'(rh), 4);
        chk("st we", 32'(fw), 1);
        chk("st be", 32'(fb), 32'h3);
        chk("st if_ack", 32'(oa), 0);
        chk("st err", 32'(er), 0);

        // Load, 1-wait memory
        xact(1, 0, 4'h3, 32'h300, 32'h0, 1, 32'h1234_5678, 0, ac, rh, oa, rd, er, fa, fb, fw);
        chk("ld latency", 32'(ac), 3);
        chk("ld rdata", rd, 32'h1234_5678);
        chk("ld be", 32'(fb), 32'hF);

        // IF drops its request mid-transaction; ack still arrives
        xact(0, 0, 4'h0, 32'h104, 32'h0, 2, 32'hCAFE_F00D, 1, ac, rh, oa, rd, er, fa, fb, fw);
        chk("drop latency", 32'(ac), 4);
        chk("drop rdata", rd, 32'hCAFE_F00D);

        // Timeout on a load that is never acked
        xact(1, 0, 4'h0, 32'h40, 32'h0, -1, 32'hAAAA_5555, 0, ac, rh, oa, rd, er, fa, fb, fw);
        chk("to latency", 32'(ac), 5);
        chk("to req cycles", 32'(rh), 4);
        chk("to err", 32'(er), 1);
        chk("to rdata", rd, 32'h0);
        chk("to addr", fa, 32'h40);
        stray = 1; cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (if_ack || dm_ack || bus_err || mem_req) cnt++;
        end
        stray = 0;
        chk("stray ack ignored", 32'(cnt), 0);

        // Contention, zero-wait memory, fresh arbiter state
        RSTn = 0; step(); RSTn = 1; step();
        lat = 0; rd_val = 32'h5;
        if_addr = 32'h500; dm_addr = 32'h600; dm_we = 0; if_req = 1; dm_req = 1;
        seq = '0; cnt = 0;
        for (int c = 0; c < 40 && cnt < 4; c++) begin
            step();
            if (if_ack || dm_ack) begin
                seq = {seq[2:0], dm_ack};
                cnt++;
                if (cnt == 3) dm_req = 0;
                if (cnt == 4) if_req = 0;
            end
        end
        if_req = 0; dm_req = 0;
        chk("contention acks", 32'(cnt), 4);
`ifdef MEM_ARB_RR_EN
        chk("contention order", 32'(seq), 32'hA);
`else
        chk("contention order", 32'(seq), 32'hE);
`endif
        step();

        // Reset while IF is granted and memory never acks
        lat = -1; if_addr = 32'h200; if_req = 1;
        step(); step();
        chk("pre-reset mem_req", 32'(mem_req), 1);
        #2 RSTn = 0;
        #1 chk("async reset mem_req", 32'(mem_req), 0);
        if_req = 0;
        step();
        RSTn = 1;
        step(); step();
        chk("post-reset mem_req", 32'(mem_req), 0);
        chk("post-reset payload", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 0);
        chk("post-reset acks", 32'({if_ack, dm_ack, bus_err, stall_if, stall_mem}), 0);
        chk("post-reset rdata", if_rdata | dm_rdata, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

endmodule
